// File: rtl/exp_align_pipe_if.sv
// Operand-in / aligned-result-out handshake bundle for exp_align_pipe.
// master = upstream/downstream environment, slave = the alignment pipe.
interface exp_align_pipe_if #(
    parameter int EXP_W  = 8,
    parameter int MANT_W = 24
);
    logic                InValid;
    logic                InReady;
    logic [EXP_W-1:0]    ExpA;
    logic [EXP_W-1:0]    ExpB;
    logic [MANT_W-1:0]   MantA;
    logic [MANT_W-1:0]   MantB;
    logic                OutValid;
    logic                OutReady;
    logic [EXP_W-1:0]    OutExp;
    logic [EXP_W-1:0]    OutDiff;
    logic                OutSwap;
    logic [MANT_W-1:0]   OutMantBig;
    logic [MANT_W+2:0]   OutMantSmall;

    modport master (
        output InValid, ExpA, ExpB, MantA, MantB, OutReady,
        input  InReady, OutValid, OutExp, OutDiff, OutSwap, OutMantBig, OutMantSmall
    );

    modport slave (
        input  InValid, ExpA, ExpB, MantA, MantB, OutReady,
        output InReady, OutValid, OutExp, OutDiff, OutSwap, OutMantBig, OutMantSmall
    );
endinterface

// File: rtl/exp_align_pipe.sv
// Two-stage elastic exponent compare (stage 1) and small-mantissa alignment
// with guard/round/sticky generation (stage 2) for the adder datapath.
module exp_align_pipe #(
    parameter int EXP_W         = 8,
    parameter int MANT_W        = 24,
    parameter int MANT_TIEBREAK = 0
) (
    input  logic           Clock,
    input  logic           Reset,
    exp_align_pipe_if.slave bus
);
    localparam int ALIGN_W = MANT_W + 2;
    localparam int SH_W    = $clog2(ALIGN_W + 1);

    // Handshake control
    logic s1ValidReg;
    logic s2ValidReg;
    logic s2CanLoad;
    logic s1Advance;
    logic inFire;

    assign s2CanLoad   = !s2ValidReg || bus.OutReady;
    assign s1Advance   = s1ValidReg && s2CanLoad;
    assign bus.InReady = !s1ValidReg || s2CanLoad;
    assign inFire      = bus.InValid && bus.InReady;

    // Stage 1: exponent compare and operand select
    logic              swapNext;
    logic [EXP_W-1:0]  diffNext;
    logic              s1SwapReg;
    logic [EXP_W-1:0]  s1ExpReg;
    logic [EXP_W-1:0]  s1DiffReg;
    logic [MANT_W-1:0] s1MantBigReg;
    logic [MANT_W-1:0] s1MantSmallReg;

    generate
        if (MANT_TIEBREAK != 0) begin : gTieMant
            assign swapNext = (bus.ExpB > bus.ExpA) ||
                              ((bus.ExpB == bus.ExpA) && (bus.MantB > bus.MantA));
        end else begin : gTieA
            assign swapNext = (bus.ExpB > bus.ExpA);
        end
    endgenerate

    // On a tie both differences are zero, so the swap choice cannot wrap Diff.
    assign diffNext = swapNext ? (bus.ExpB - bus.ExpA) : (bus.ExpA - bus.ExpB);

    // Stage 2: alignment of the small mantissa (combinational from stage 1)
    logic [ALIGN_W-1:0] alignExt;
    logic [ALIGN_W-1:0] alignShifted;
    logic [ALIGN_W-1:0] alignLost;
    logic [SH_W-1:0]    shAmt;
    logic               alignSticky;

    assign alignExt = {s1MantSmallReg, 2'b00};

    // Saturate the shift so any difference past the full width flushes everything into S.
    always_comb begin
        shAmt = SH_W'(s1DiffReg);
        if (32'(s1DiffReg) >= $unsigned(ALIGN_W)) begin
            shAmt = SH_W'(ALIGN_W);
        end
    end

    assign alignShifted = alignExt >> shAmt;

    genvar gi;
    generate
        for (gi = 0; gi < ALIGN_W; gi++) begin : gLost
            assign alignLost[gi] = alignExt[gi] && (SH_W'(gi) < shAmt);
        end
    endgenerate

    assign alignSticky = |alignLost;

    logic              s2SwapReg;
    logic [EXP_W-1:0]  s2ExpReg;
    logic [EXP_W-1:0]  s2DiffReg;
    logic [MANT_W-1:0] s2MantBigReg;
    logic [MANT_W+2:0] s2MantSmallReg;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            s1ValidReg     <= 1'b0;
            s1SwapReg      <= 1'b0;
            s1ExpReg       <= '0;
            s1DiffReg      <= '0;
            s1MantBigReg   <= '0;
            s1MantSmallReg <= '0;
            s2ValidReg     <= 1'b0;
            s2SwapReg      <= 1'b0;
            s2ExpReg       <= '0;
            s2DiffReg      <= '0;
            s2MantBigReg   <= '0;
            s2MantSmallReg <= '0;
        end else begin
            if (inFire) begin
                s1ValidReg     <= 1'b1;
                s1SwapReg      <= swapNext;
                s1ExpReg       <= swapNext ? bus.ExpB  : bus.ExpA;
                s1DiffReg      <= diffNext;
                s1MantBigReg   <= swapNext ? bus.MantB : bus.MantA;
                s1MantSmallReg <= swapNext ? bus.MantA : bus.MantB;
            end else if (s1Advance) begin
                s1ValidReg <= 1'b0;
            end

            // Output data only changes on a load, which keeps Out* frozen while stalled.
            if (s2CanLoad) begin
                s2ValidReg <= s1ValidReg;
                if (s1ValidReg) begin
                    s2SwapReg      <= s1SwapReg;
                    s2ExpReg       <= s1ExpReg;
                    s2DiffReg      <= s1DiffReg;
                    s2MantBigReg   <= s1MantBigReg;
                    s2MantSmallReg <= {alignShifted, alignSticky};
                end
            end
        end
    end

    assign bus.OutValid     = s2ValidReg;
    assign bus.OutSwap      = s2SwapReg;
    assign bus.OutExp       = s2ExpReg;
    assign bus.OutDiff      = s2DiffReg;
    assign bus.OutMantBig   = s2MantBigReg;
    assign bus.OutMantSmall = s2MantSmallReg;
endmodule

// File: tb/tb_exp_align_pipe.sv
// Randomised bench for exp_align_pipe: two instances (tie rule off/on) share
// stimulus and are scored against an arithmetic reference with an entry queue.
module tb_exp_align_pipe;
    logic clk  = 1'b0;
    logic srst = 1'b1;

    always #5 clk = ~clk;

    exp_align_pipe_if #(.EXP_W(8), .MANT_W(24)) bus0 ();
    exp_align_pipe_if #(.EXP_W(8), .MANT_W(24)) bus1 ();

    exp_align_pipe #(.EXP_W(8), .MANT_W(24), .MANT_TIEBREAK(0)) dut0 (
        .Clock(clk), .Reset(srst), .bus(bus0.slave)
    );
    exp_align_pipe #(.EXP_W(8), .MANT_W(24), .MANT_TIEBREAK(1)) dut1 (
        .Clock(clk), .Reset(srst), .bus(bus1.slave)
    );

    typedef struct {
        logic [7:0]  expA;
        logic [7:0]  expB;
        logic [23:0] mantA;
        logic [23:0] mantB;
        int          acc;
    } inRec_t;

    inRec_t inQ[$];
    int     cyc          = 0;
    int     checksTotal  = 0;
    int     checksPassed = 0;
    bit     zeroCheck    = 0;

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checksTotal++;
        if (obs !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end else begin
            checksPassed++;
        end
    endtask

    // Reference: pick the big operand, then divide the x4-scaled small mantissa
    // by 2^diff; the remainder being nonzero is exactly the sticky condition.
    function automatic void refModel(input inRec_t r, input bit tie,
                                     output logic [7:0] eExp, output logic [7:0] eDiff,
                                     output logic eSwap, output logic [23:0] eBig,
                                     output logic [26:0] eSmall);
        int     a = int'(r.expA);
        int     b = int'(r.expB);
        int     d;
        bit     sw;
        bit     s;
        longint ext;
        longint pw;
        longint q;
        sw    = (b > a) || (tie && (a == b) && (r.mantB > r.mantA));
        d     = sw ? (b - a) : (a - b);
        eSwap = sw;
        eExp  = sw ? r.expB : r.expA;
        eDiff = 8'(d);
        eBig  = sw ? r.mantB : r.mantA;
        ext   = longint'(sw ? r.mantA : r.mantB) * 4;
        if (d >= 26) begin
            q = 0;
            s = (ext != 0);
        end else begin
            pw = longint'(1) << d;
            q  = ext / pw;
            s  = (ext % pw) != 0;
        end
        eSmall = 27'(q * 2 + longint'(s));
    endfunction

    task automatic checkDut(input string tag, input bit tie, input bit expOv, input bit expIr,
                            input logic ir, input logic ov, input logic [7:0] oExp,
                            input logic [7:0] oDiff, input logic oSwap,
                            input logic [23:0] oBig, input logic [26:0] oSmall);
        logic [7:0]  eExp;
        logic [7:0]  eDiff;
        logic        eSwap;
        logic [23:0] eBig;
        logic [26:0] eSmall;
        checkVal({tag, ".InReady"}, 64'(ir), 64'(expIr));
        checkVal({tag, ".OutValid"}, 64'(ov), 64'(expOv));
        if (zeroCheck) begin
            checkVal({tag, ".rstExp"}, 64'(oExp), 64'd0);
            checkVal({tag, ".rstDiff"}, 64'(oDiff), 64'd0);
            checkVal({tag, ".rstSwap"}, 64'(oSwap), 64'd0);
            checkVal({tag, ".rstBig"}, 64'(oBig), 64'd0);
            checkVal({tag, ".rstSmall"}, 64'(oSmall), 64'd0);
        end
        if (expOv) begin
            refModel(inQ[0], tie, eExp, eDiff, eSwap, eBig, eSmall);
            checkVal({tag, ".OutExp"}, 64'(oExp), 64'(eExp));
            checkVal({tag, ".OutDiff"}, 64'(oDiff), 64'(eDiff));
            checkVal({tag, ".OutSwap"}, 64'(oSwap), 64'(eSwap));
            checkVal({tag, ".OutMantBig"}, 64'(oBig), 64'(eBig));
            checkVal({tag, ".OutMantSmall"}, 64'(oSmall), 64'(eSmall));
        end
    endtask

    // One clock cycle: drive, settle, score both instances, update the model.
    task automatic step(input bit iv, input inRec_t r, input bit ordy, input bit doRst,
                        output bit accepted);
        bit expOv;
        bit expIr;
        @(negedge clk);
        srst          = doRst;
        bus0.InValid  = iv;   bus1.InValid  = iv;
        bus0.ExpA     = r.expA;  bus1.ExpA  = r.expA;
        bus0.ExpB     = r.expB;  bus1.ExpB  = r.expB;
        bus0.MantA    = r.mantA; bus1.MantA = r.mantA;
        bus0.MantB    = r.mantB; bus1.MantB = r.mantB;
        bus0.OutReady = ordy; bus1.OutReady = ordy;
        #1;
        accepted = 1'b0;
        if (doRst) begin
            inQ.delete();
            zeroCheck = 1'b1;
        end else begin
            // An entry reaches the output two cycles after the cycle it was accepted in.
            expOv = (inQ.size() > 0) && (cyc >= inQ[0].acc + 2);
            expIr = (inQ.size() < 2) || ordy;
            checkDut("tie0", 1'b0, expOv, expIr, bus0.InReady, bus0.OutValid, bus0.OutExp,
                     bus0.OutDiff, bus0.OutSwap, bus0.OutMantBig, bus0.OutMantSmall);
            checkDut("tie1", 1'b1, expOv, expIr, bus1.InReady, bus1.OutValid, bus1.OutExp,
                     bus1.OutDiff, bus1.OutSwap, bus1.OutMantBig, bus1.OutMantSmall);
            zeroCheck = 1'b0;
            if (expOv && ordy) void'(inQ.pop_front());
            if (iv && expIr) begin
                r.acc = cyc;
                inQ.push_back(r);
                accepted = 1'b1;
            end
        end
        cyc++;
    endtask

    function automatic inRec_t randRec();
        inRec_t r;
        int     mode = int'($urandom_range(0, 4));
        r.expA  = 8'($urandom);
        r.mantA = 24'($urandom);
        r.mantB = 24'($urandom);
        case (mode)
            0: r.expB = 8'($urandom);
            1: r.expB = r.expA + 8'($urandom_range(0, 6)) - 8'd3;
            2: r.expB = r.expA;
            3: r.expB = r.expA + 8'($urandom_range(20, 32));
            default: begin
                r.expB  = r.expA - 8'($urandom_range(20, 32));
                r.mantB = r.mantB & 24'($urandom_range(0, 15));
            end
        endcase
        if ($urandom_range(0, 3) == 0) r.mantA[23] = 1'b1;
        r.acc = 0;
        return r;
    endfunction

    function automatic inRec_t mk(input logic [7:0] ea, input logic [7:0] eb,
                                  input logic [23:0] ma, input logic [23:0] mb);
        inRec_t r;
        r.expA = ea; r.expB = eb; r.mantA = ma; r.mantB = mb; r.acc = 0;
        return r;
    endfunction

    inRec_t dirVec[5];
    inRec_t idleRec;
    inRec_t cur;
    bit     acc;

    initial begin
        idleRec = mk(8'h00, 8'h00, 24'h0, 24'h0);
        dirVec[0] = mk(8'h85, 8'h82, 24'h800000, 24'hC00000);
        dirVec[1] = mk(8'h10, 8'h20, 24'h800001, 24'h800000);
        dirVec[2] = mk(8'h90, 8'h10, 24'h800000, 24'h000001);
        dirVec[3] = mk(8'h90, 8'h10, 24'h800000, 24'h000000);
        dirVec[4] = mk(8'h7F, 8'h7F, 24'h900000, 24'hA00000);

        for (int i = 0; i < 3; i++) step(1'b0, idleRec, 1'b1, 1'b1, acc);
        for (int i = 0; i < 2; i++) step(1'b0, idleRec, 1'b1, 1'b0, acc);

        // Directed vectors streamed back to back, then drained.
        for (int i = 0; i < 5; i++) begin
            acc = 1'b0;
            for (int t = 0; t < 8 && !acc; t++) step(1'b1, dirVec[i], 1'b1, 1'b0, acc);
        end
        for (int i = 0; i < 4; i++) step(1'b0, idleRec, 1'b1, 1'b0, acc);

        // Backpressure: offer 4 entries while the output is blocked for 4 cycles.
        begin
            int sent = 0;
            cur = randRec();
            for (int t = 0; t < 20; t++) begin
                step(sent < 4, cur, t >= 4, 1'b0, acc);
                if (acc) begin
                    sent++;
                    cur = randRec();
                end
            end
        end

        // Reset with two entries in flight.
        step(1'b1, randRec(), 1'b0, 1'b0, acc);
        step(1'b1, randRec(), 1'b0, 1'b0, acc);
        step(1'b0, idleRec, 1'b0, 1'b1, acc);
        for (int i = 0; i < 5; i++) step(1'b0, idleRec, 1'b1, 1'b0, acc);

        // Random traffic with random backpressure; inputs held until accepted.
        cur = randRec();
        for (int t = 0; t < 2000; t++) begin
            step($urandom_range(0, 9) < 7, cur, $urandom_range(0, 9) < 6, 1'b0, acc);
            if (acc) cur = randRec();
        end
        for (int i = 0; i < 6; i++) step(1'b0, idleRec, 1'b1, 1'b0, acc);
        checkVal("drainedQueue", 64'(inQ.size()), 64'd0);

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end
endmodule
